// File: rtl/alu_rs_sched.sv
`default_nettype none
// =============================================================================
// Module      : alu_rs_sched
// Description : ALU reservation station with CDB wakeup, oldest-ready issue
//               and a one-deep valid/ready result stage toward the CDB.
// Revision    : 1.0
// =============================================================================
`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif

module alu_rs_sched #(
    parameter int RS_DEPTH = 4,
    parameter int ROB_W    = `ROB_ENTRY_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [3:0]       disp_op,
    input  logic [31:0]      disp_vj,
    input  logic [31:0]      disp_vk,
    input  logic             disp_qj_pend,
    input  logic             disp_qk_pend,
    input  logic [ROB_W-1:0] disp_qj,
    input  logic [ROB_W-1:0] disp_qk,
    input  logic [ROB_W-1:0] disp_dest,
    input  logic             cdb_valid,
    input  logic [ROB_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_value,
    input  logic             flush,
    output logic [3:0]       alu_op,
    output logic [31:0]      alu_a,
    output logic [31:0]      alu_b,
    output logic [ROB_W-1:0] alu_dest,
    input  logic [31:0]      alu_res,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ROB_W-1:0] out_tag,
    output logic [31:0]      out_value
);

    localparam int c_idx_w = $clog2(RS_DEPTH);

    logic [RS_DEPTH-1:0] valid_q, valid_d;
    logic [RS_DEPTH-1:0] qjp_q, qjp_d;
    logic [RS_DEPTH-1:0] qkp_q, qkp_d;
    logic [3:0]          op_q   [RS_DEPTH];
    logic [3:0]          op_d   [RS_DEPTH];
    logic [31:0]         vj_q   [RS_DEPTH];
    logic [31:0]         vj_d   [RS_DEPTH];
    logic [31:0]         vk_q   [RS_DEPTH];
    logic [31:0]         vk_d   [RS_DEPTH];
    logic [ROB_W-1:0]    qj_q   [RS_DEPTH];
    logic [ROB_W-1:0]    qj_d   [RS_DEPTH];
    logic [ROB_W-1:0]    qk_q   [RS_DEPTH];
    logic [ROB_W-1:0]    qk_d   [RS_DEPTH];
    logic [ROB_W-1:0]    dest_q [RS_DEPTH];
    logic [ROB_W-1:0]    dest_d [RS_DEPTH];
    // older_q[i][j] set means entry i was dispatched before entry j
    logic [RS_DEPTH-1:0] older_q [RS_DEPTH];
    logic [RS_DEPTH-1:0] older_d [RS_DEPTH];

    logic             out_valid_q, out_valid_d;
    logic [ROB_W-1:0] out_tag_q, out_tag_d;
    logic [31:0]      out_value_q, out_value_d;

    logic [RS_DEPTH-1:0] w_ready;
    logic [RS_DEPTH-1:0] w_sel;
    logic [c_idx_w-1:0]  w_issue_idx;
    logic [c_idx_w-1:0]  w_free_idx;
    logic                w_do_issue;
    logic                w_do_disp;
    logic                w_dj_hit;
    logic                w_dk_hit;

    always_comb begin
        w_ready = valid_q & ~qjp_q & ~qkp_q;
        for (int i = 0; i < RS_DEPTH; i++) begin
            w_sel[i] = w_ready[i];
            for (int j = 0; j < RS_DEPTH; j++) begin
                if (j != i && w_ready[j] && older_q[j][i]) begin
                    w_sel[i] = 1'b0;
                end
            end
        end
        w_issue_idx = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (w_sel[i]) begin
                w_issue_idx = c_idx_w'(i);
            end
        end
        w_free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!valid_q[i]) begin
                w_free_idx = c_idx_w'(i);
            end
        end
    end

    assign disp_ready = ~&valid_q;
    assign w_do_issue = (!out_valid_q || out_ready) && (|w_ready) && !flush;
    assign w_do_disp  = disp_valid && disp_ready && !flush;
    assign w_dj_hit   = cdb_valid && disp_qj_pend && (cdb_tag == disp_qj);
    assign w_dk_hit   = cdb_valid && disp_qk_pend && (cdb_tag == disp_qk);

    assign alu_op   = w_do_issue ? op_q[w_issue_idx] : 4'd0;
    assign alu_a    = vj_q[w_issue_idx];
    assign alu_b    = vk_q[w_issue_idx];
    assign alu_dest = dest_q[w_issue_idx];

    assign out_valid = out_valid_q;
    assign out_tag   = out_tag_q;
    assign out_value = out_value_q;

    always_comb begin
        valid_d = valid_q;
        qjp_d   = qjp_q;
        qkp_d   = qkp_q;
        op_d    = op_q;
        vj_d    = vj_q;
        vk_d    = vk_q;
        qj_d    = qj_q;
        qk_d    = qk_q;
        dest_d  = dest_q;
        older_d = older_q;

        for (int i = 0; i < RS_DEPTH; i++) begin
            if (valid_q[i] && qjp_q[i] && cdb_valid && (cdb_tag == qj_q[i])) begin
                vj_d[i]  = cdb_value;
                qjp_d[i] = 1'b0;
            end
            if (valid_q[i] && qkp_q[i] && cdb_valid && (cdb_tag == qk_q[i])) begin
                vk_d[i]  = cdb_value;
                qkp_d[i] = 1'b0;
            end
        end

        if (w_do_issue) begin
            valid_d[w_issue_idx] = 1'b0;
        end

        // The free slot is invalid in the current state, so it never collides with the issuing entry
        if (w_do_disp) begin
            valid_d[w_free_idx] = 1'b1;
            op_d[w_free_idx]    = disp_op;
            vj_d[w_free_idx]    = w_dj_hit ? cdb_value : disp_vj;
            vk_d[w_free_idx]    = w_dk_hit ? cdb_value : disp_vk;
            qjp_d[w_free_idx]   = disp_qj_pend && !w_dj_hit;
            qkp_d[w_free_idx]   = disp_qk_pend && !w_dk_hit;
            qj_d[w_free_idx]    = disp_qj;
            qk_d[w_free_idx]    = disp_qk;
            dest_d[w_free_idx]  = disp_dest;
            older_d[w_free_idx] = '0;
            for (int j = 0; j < RS_DEPTH; j++) begin
                older_d[j][w_free_idx] = valid_q[j];
            end
        end

        if (flush) begin
            valid_d = '0;
        end

        out_valid_d = out_valid_q;
        out_tag_d   = out_tag_q;
        out_value_d = out_value_q;
        if (flush) begin
            out_valid_d = 1'b0;
        end else if (w_do_issue) begin
            out_valid_d = 1'b1;
            out_tag_d   = dest_q[w_issue_idx];
            out_value_d = alu_res;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q     <= '0;
            qjp_q       <= '0;
            qkp_q       <= '0;
            for (int i = 0; i < RS_DEPTH; i++) begin
                op_q[i]    <= '0;
                vj_q[i]    <= '0;
                vk_q[i]    <= '0;
                qj_q[i]    <= '0;
                qk_q[i]    <= '0;
                dest_q[i]  <= '0;
                older_q[i] <= '0;
            end
            out_valid_q <= 1'b0;
            out_tag_q   <= '0;
            out_value_q <= '0;
        end else begin
            valid_q     <= valid_d;
            qjp_q       <= qjp_d;
            qkp_q       <= qkp_d;
            op_q        <= op_d;
            vj_q        <= vj_d;
            vk_q        <= vk_d;
            qj_q        <= qj_d;
            qk_q        <= qk_d;
            dest_q      <= dest_d;
            older_q     <= older_d;
            out_valid_q <= out_valid_d;
            out_tag_q   <= out_tag_d;
            out_value_q <= out_value_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_alu_rs_sched.sv
`default_nettype none
`timescale 1ns/1ps
// =============================================================================
// Module      : tb_alu_rs_sched
// Description : Directed self-checking bench for alu_rs_sched with an ALU model.
// Revision    : 1.0
// =============================================================================

module tb_alu_rs_sched;

    localparam int         c_rob_w  = 4;
    localparam logic [3:0] c_op_add = 4'd1;
    localparam logic [3:0] c_op_sub = 4'd2;

    logic               clk;
    logic               rst;
    logic               disp_valid;
    logic               disp_ready;
    logic [3:0]         disp_op;
    logic [31:0]        disp_vj;
    logic [31:0]        disp_vk;
    logic               disp_qj_pend;
    logic               disp_qk_pend;
    logic [c_rob_w-1:0] disp_qj;
    logic [c_rob_w-1:0] disp_qk;
    logic [c_rob_w-1:0] disp_dest;
    logic               cdb_valid;
    logic [c_rob_w-1:0] cdb_tag;
    logic [31:0]        cdb_value;
    logic               flush;
    logic [3:0]         alu_op;
    logic [31:0]        alu_a;
    logic [31:0]        alu_b;
    logic [c_rob_w-1:0] alu_dest;
    logic [31:0]        alu_res;
    logic               out_valid;
    logic               out_ready;
    logic [c_rob_w-1:0] out_tag;
    logic [31:0]        out_value;

    int checks = 0;
    int errors = 0;

    alu_rs_sched #(.RS_DEPTH(4), .ROB_W(c_rob_w)) dut (
        .clk(clk), .rst(rst),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk),
        .disp_qj_pend(disp_qj_pend), .disp_qk_pend(disp_qk_pend),
        .disp_qj(disp_qj), .disp_qk(disp_qk), .disp_dest(disp_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .flush(flush),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_dest(alu_dest),
        .alu_res(alu_res),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_tag(out_tag), .out_value(out_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Combinational ALU stand-in
    always_comb begin
        case (alu_op)
            c_op_add: alu_res = alu_a + alu_b;
            c_op_sub: alu_res = alu_a - alu_b;
            default:  alu_res = 32'd0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock; single-cycle pulses are dropped right after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        disp_valid = 1'b0;
        cdb_valid  = 1'b0;
        flush      = 1'b0;
    endtask

    task automatic set_disp(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                            input logic qjp, input logic [3:0] qj,
                            input logic qkp, input logic [3:0] qk, input logic [3:0] dest);
        disp_valid   = 1'b1;
        disp_op      = op;
        disp_vj      = vj;
        disp_vk      = vk;
        disp_qj_pend = qjp;
        disp_qj      = qj;
        disp_qk_pend = qkp;
        disp_qk      = qk;
        disp_dest    = dest;
    endtask

    task automatic set_cdb(input logic [3:0] tag, input logic [31:0] value);
        cdb_valid = 1'b1;
        cdb_tag   = tag;
        cdb_value = value;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
        disp_valid = 1'b0; disp_op = '0; disp_vj = '0; disp_vk = '0;
        disp_qj_pend = 1'b0; disp_qk_pend = 1'b0; disp_qj = '0; disp_qk = '0; disp_dest = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_value = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_tag", 32'(out_tag), 32'd0);
        check("rst_out_value", out_value, 32'd0);
        check("rst_alu_op", 32'(alu_op), 32'd0);
        check("rst_disp_ready", 32'(disp_ready), 32'd1);
        rst = 1'b0;
        tick();

        // ADD with ready operands
        set_disp(c_op_add, 32'd5, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
        tick(); #1;
        check("add_alu_op", 32'(alu_op), 32'(c_op_add));
        check("add_alu_a", alu_a, 32'd5);
        check("add_alu_b", alu_b, 32'd7);
        check("add_alu_dest", 32'(alu_dest), 32'd2);
        check("add_out_valid_early", 32'(out_valid), 32'd0);
        tick();
        check("add_out_valid", 32'(out_valid), 32'd1);
        check("add_out_tag", 32'(out_tag), 32'd2);
        check("add_out_value", out_value, 32'd12);
        check("add_idle_op", 32'(alu_op), 32'd0);
        tick();
        check("add_out_drain", 32'(out_valid), 32'd0);

        // SUB waiting on tag 3, woken by a later broadcast
        set_disp(c_op_sub, 32'd0, 32'd1, 1'b1, 4'd3, 1'b0, 4'd0, 4'd4);
        tick(); #1;
        check("sub_wait_op", 32'(alu_op), 32'd0);
        set_cdb(4'd3, 32'd10); #1;
        check("sub_no_bypass", 32'(alu_op), 32'd0);
        tick(); #1;
        check("sub_issue_op", 32'(alu_op), 32'(c_op_sub));
        check("sub_issue_a", alu_a, 32'd10);
        tick();
        check("sub_out_tag", 32'(out_tag), 32'd4);
        check("sub_out_value", out_value, 32'd9);
        tick();

        // Same SUB with the broadcast in the dispatch cycle
        set_disp(c_op_sub, 32'd0, 32'd1, 1'b1, 4'd3, 1'b0, 4'd0, 4'd4);
        set_cdb(4'd3, 32'd10);
        tick(); #1;
        check("subd_issue_op", 32'(alu_op), 32'(c_op_sub));
        check("subd_issue_a", alu_a, 32'd10);
        tick();
        check("subd_out_valid", 32'(out_valid), 32'd1);
        check("subd_out_value", out_value, 32'd9);
        tick();

        // Fill the station behind a stalled output stage
        out_ready = 1'b0;
        set_disp(c_op_add, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
        tick();
        set_disp(c_op_add, 32'd2, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
        tick();
        check("fill_first_value", out_value, 32'd2);
        set_disp(c_op_add, 32'd3, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        tick();
        set_disp(c_op_add, 32'd4, 32'd4, 1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
        tick(); #1;
        check("fill_three_ready", 32'(disp_ready), 32'd1);
        set_disp(c_op_add, 32'd5, 32'd5, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6);
        tick(); #1;
        check("full_disp_ready", 32'(disp_ready), 32'd0);
        check("full_stall_op", 32'(alu_op), 32'd0);
        tick();
        check("full_hold_valid", 32'(out_valid), 32'd1);
        check("full_hold_tag", 32'(out_tag), 32'd1);
        check("full_hold_value", out_value, 32'd2);
        out_ready = 1'b1; #1;
        check("full_issue_disp_ready", 32'(disp_ready), 32'd0);
        check("full_issue_dest", 32'(alu_dest), 32'd2);
        tick();
        check("drain_b_value", out_value, 32'd4);
        check("drain_b_tag", 32'(out_tag), 32'd2);
        tick();
        check("drain_c_value", out_value, 32'd6);
        check("drain_c_tag", 32'(out_tag), 32'd3);
        tick();
        check("drain_d_value", out_value, 32'd8);
        check("drain_d_tag", 32'(out_tag), 32'd5);
        tick();
        check("drain_e_value", out_value, 32'd10);
        check("drain_e_valid", 32'(out_valid), 32'd1);
        tick();
        check("drain_done", 32'(out_valid), 32'd0);

        // Older entry in a higher slot must still win
        set_disp(c_op_add, 32'd0, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0, 4'd10);
        tick();
        set_disp(c_op_sub, 32'd0, 32'd3, 1'b1, 4'd7, 1'b0, 4'd0, 4'd8);
        set_cdb(4'd12, 32'd1);
        tick(); #1;
        check("age_x_dest", 32'(alu_dest), 32'd10);
        tick();
        check("age_x_value", out_value, 32'd1);
        set_disp(c_op_add, 32'd100, 32'd0, 1'b0, 4'd0, 1'b1, 4'd7, 4'd9);
        tick();
        set_cdb(4'd7, 32'd20); #1;
        check("age_wake_op", 32'(alu_op), 32'd0);
        tick(); #1;
        check("age_first_dest", 32'(alu_dest), 32'd8);
        check("age_first_a", alu_a, 32'd20);
        tick(); #1;
        check("age_a_value", out_value, 32'd17);
        check("age_second_dest", 32'(alu_dest), 32'd9);
        check("age_second_b", alu_b, 32'd20);
        tick();
        check("age_b_tag", 32'(out_tag), 32'd9);
        check("age_b_value", out_value, 32'd120);
        tick();

        // Flush with pending entries, a held result and a colliding dispatch
        out_ready = 1'b0;
        set_disp(c_op_add, 32'd1, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd13);
        tick();
        set_disp(c_op_add, 32'd0, 32'd0, 1'b1, 4'd5, 1'b0, 4'd0, 4'd11);
        tick();
        set_disp(c_op_add, 32'd0, 32'd0, 1'b0, 4'd0, 1'b1, 4'd6, 4'd12);
        tick();
        check("flush_pre_valid", 32'(out_valid), 32'd1);
        check("flush_pre_value", out_value, 32'd3);
        flush = 1'b1;
        set_disp(c_op_add, 32'd9, 32'd9, 1'b0, 4'd0, 1'b0, 4'd0, 4'd14);
        tick(); #1;
        check("flush_out_valid", 32'(out_valid), 32'd0);
        check("flush_no_disp", 32'(alu_op), 32'd0);
        check("flush_disp_ready", 32'(disp_ready), 32'd1);
        set_cdb(4'd5, 32'd1);
        tick();
        set_cdb(4'd6, 32'd1); #1;
        check("flush_cdb5_op", 32'(alu_op), 32'd0);
        tick(); #1;
        check("flush_cdb6_op", 32'(alu_op), 32'd0);
        check("flush_cdb6_valid", 32'(out_valid), 32'd0);

        // Asynchronous reset mid-operation
        set_disp(c_op_add, 32'd1, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1);
        tick();
        set_disp(c_op_add, 32'd0, 32'd0, 1'b1, 4'd5, 1'b0, 4'd0, 4'd2);
        tick();
        set_disp(c_op_add, 32'd0, 32'd0, 1'b1, 4'd6, 1'b0, 4'd0, 4'd3);
        tick();
        set_disp(c_op_add, 32'd0, 32'd0, 1'b1, 4'd7, 1'b0, 4'd0, 4'd4);
        tick();
        check("mid_pre_valid", 32'(out_valid), 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_tag", 32'(out_tag), 32'd0);
        check("mid_rst_value", out_value, 32'd0);
        check("mid_rst_op", 32'(alu_op), 32'd0);
        #1;
        rst = 1'b0;
        tick();
        check("mid_rel_ready", 32'(disp_ready), 32'd1);
        out_ready = 1'b1;
        set_cdb(4'd5, 32'd1);
        tick(); #1;
        check("mid_rel_no_issue", 32'(alu_op), 32'd0);
        check("mid_rel_out", 32'(out_valid), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
